rice_unpacker: RTL

RICE_UNPACKER -- requirements
Module: rice_unpacker

---
 rtl/rice_pkg.sv | 13 +
 rtl/count_lead_zero.sv | 22 ++
 rtl/rice_unpacker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rice_pkg.sv
// Shared types and default widths for the Rice bitstream unpacker.
package rice_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    ERR = 1'b1
  } state_e;

  localparam int DEF_W_WORD = 32;
  localparam int DEF_W_VAL  = 32;
  localparam int DEF_K_W    = 4;

endpackage

// File: rtl/count_lead_zero.sv
// Leading-zero counter; an all-zero input returns W_IN.
module count_lead_zero #(
  parameter int W_IN  = 32,
  parameter int W_OUT = $clog2(W_IN) + 1
) (
  input  logic [W_IN-1:0]  data_i,
  output logic [W_OUT-1:0] count_o
);

  logic [W_OUT-1:0] cnt;

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    cnt = W_OUT'(W_IN);
    for (int i = 0; i < W_IN; i++) begin
      if (data_i[i]) cnt = W_OUT'(W_IN - 1 - i);
    end
  end

  assign count_o = cnt;

endmodule

// File: rtl/rice_unpacker.sv
// Rice-code decoder: buffers MSB-first words and emits one (q << k) | r value per cycle.
module rice_unpacker
  import rice_pkg::*;
#(
  parameter int W_WORD = DEF_W_WORD,
  parameter int W_VAL  = DEF_W_VAL,
  parameter int K_W    = DEF_K_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [K_W-1:0]    k_i,
  input  logic              flush_i,
  input  logic [W_WORD-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_VAL-1:0]  out_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_o
);

  localparam int BW = 2 * W_WORD;
  localparam int FW = $clog2(BW) + 1;
  localparam int QW = $clog2(W_WORD) + 1;
  localparam int LW = ((FW > K_W) ? FW : K_W) + 1;
  localparam logic [FW-1:0] FILL_WORD = FW'(W_WORD);

  state_e            state_q, state_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [W_VAL-1:0]  out_value_q, out_value_d;
  logic              out_valid_q, out_valid_d;

  logic [QW-1:0]     q_cnt;
  logic [LW-1:0]     sym_len;
  logic [LW-1:0]     rem_sh;
  logic [BW-1:0]     after_stop;
  logic [BW-1:0]     rem_bits;
  logic [W_VAL-1:0]  sym_value;
  logic              win_full, all_zero, out_free, accept, decode;
  logic [BW-1:0]     shifted;
  logic [FW-1:0]     fill_s;
  logic [BW-1:0]     incoming;

  count_lead_zero #(
    .W_IN (W_WORD),
    .W_OUT(QW)
  ) u_clz (
    .data_i (buf_q[BW-1 -: W_WORD]),
    .count_o(q_cnt)
  );

  assign win_full = (fill_q >= FILL_WORD);
  assign all_zero = (q_cnt == QW'(W_WORD));
  assign sym_len  = LW'(q_cnt) + LW'(k_i) + LW'(1);
  assign out_free = !out_valid_q || out_ready;

  assign in_ready = (state_q == RUN) && (fill_q <= FILL_WORD);
  assign accept   = in_valid && in_ready;
  assign decode   = (state_q == RUN) && win_full && !all_zero &&
                    (LW'(fill_q) >= sym_len) && out_free;

  // Remainder: drop the unary run and stop bit, then keep the top k bits.
  assign after_stop = buf_q << (q_cnt + QW'(1));
  assign rem_sh     = LW'(BW) - LW'(k_i);
  assign rem_bits   = after_stop >> rem_sh;
  assign sym_value  = (W_VAL'(q_cnt) << k_i) | W_VAL'(rem_bits);

  // A word accepted alongside a decode lands just below the post-shift fill.
  assign shifted  = decode ? (buf_q << sym_len) : buf_q;
  assign fill_s   = decode ? (fill_q - FW'(sym_len)) : fill_q;
  assign incoming = {in_data, {W_WORD{1'b0}}} >> fill_s;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      state_d     = RUN;
      buf_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (decode) begin
        out_value_d = sym_value;
        out_valid_d = 1'b1;
      end
      buf_d  = shifted;
      fill_d = fill_s;
      if (accept) begin
        buf_d  = shifted | incoming;
        fill_d = fill_s + FILL_WORD;
      end
      if ((state_q == RUN) && win_full && all_zero) state_d = ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      buf_q       <= '0;
      fill_q      <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_value = out_value_q;
  assign out_valid = out_valid_q;
  assign err_o     = (state_q == ERR);

endmodule
